// File: rtl/aes_pkg.sv
// Shared types and constants for the AES decryption round sequencer.
package aes_pkg;

  localparam int AES128_ROUNDS = 10;
  localparam int AES_KEY_IDX_W = 4;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_dec_state_t;

endpackage

// File: rtl/aes_round_counter.sv
// Loadable round down-counter; saturates at zero and flags the terminal round.
module aes_round_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES decryption sequencer driving an external inverse-round datapath.
// Optional AES_DEC_KEY_STALL_EN adds key_valid to stall on a slow key store.
module aes_dec_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int KEY_IDX_W  = AES_KEY_IDX_W
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [127:0]         round_key,
`ifdef AES_DEC_KEY_STALL_EN
  input  logic                 key_valid,
`endif
  output logic [127:0]         dp_state,
  output logic [127:0]         dp_key,
  output logic                 dp_last,
  input  logic [127:0]         dp_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic                 busy
);

  aes_dec_state_t state_d, state_q;
  aes_block_t     blk_d, blk_q;
  logic                 cnt_load, cnt_en, cnt_zero;
  logic [KEY_IDX_W-1:0] cnt;
  logic                 key_ok;

`ifdef AES_DEC_KEY_STALL_EN
  assign key_ok = key_valid;
`else
  assign key_ok = 1'b1;
`endif

  aes_round_counter #(.W(KEY_IDX_W)) u_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (KEY_IDX_W'(NUM_ROUNDS - 1)),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    dp_last   = 1'b0;
    key_idx   = KEY_IDX_W'(NUM_ROUNDS);
    case (state_q)
      IDLE: begin
        in_ready = key_ok;
        // Initial AddRoundKey uses the last round key, selected by the IDLE key_idx.
        if (in_valid && key_ok) begin
          blk_d    = in_data ^ round_key;
          cnt_load = 1'b1;
          state_d  = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        key_idx = cnt;
        dp_last = cnt_zero;
        if (key_ok) begin
          blk_d  = dp_result;
          cnt_en = 1'b1;
          if (cnt_zero) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        key_idx   = cnt;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
    end
  end

  assign dp_state = blk_q;
  assign dp_key   = round_key;
  assign out_data = blk_q;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: real AES key store and inverse-round datapath,
// cycle-level reference model, directed FIPS-197 cases and random traffic.
`timescale 1ns/1ps
module tb_aes_dec_round_ctrl;
  localparam int NR = 10;
  localparam int KW = 4;
  localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0, n_rst = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [127:0] in_data = '0;
  logic [KW-1:0] key_idx;
  logic [127:0] round_key, dp_state, dp_key, dp_result, out_data;
  logic dp_last, out_valid, busy;
  logic out_ready = 1'b0, key_valid = 1'b1;

  logic [7:0]   sbox[256], isbox[256];
  logic [127:0] rk[16];
  int vectors = 0, errs = 0, cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  aes_dec_round_ctrl #(.NUM_ROUNDS(NR), .KEY_IDX_W(KW)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_idx(key_idx), .round_key(round_key),
`ifdef AES_DEC_KEY_STALL_EN
    .key_valid(key_valid),
`endif
    .dp_state(dp_state), .dp_key(dp_key), .dp_last(dp_last), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] y, input int n);
    logic [15:0] d;
    d = {y, y} << n;
    return d[15:8];
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
  endtask

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] a[16], t[16];
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        a[4*c+w] = isbox[gb(s, 4*((c - w + 4) % 4) + w)] ^ gb(k, 4*c+w);
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int w = 0; w < 4; w++) t[4*c+w] = a[4*c+w];
      end else begin
        t[4*c]   = gmul(a[4*c],8'h0e)^gmul(a[4*c+1],8'h0b)^gmul(a[4*c+2],8'h0d)^gmul(a[4*c+3],8'h09);
        t[4*c+1] = gmul(a[4*c],8'h09)^gmul(a[4*c+1],8'h0e)^gmul(a[4*c+2],8'h0b)^gmul(a[4*c+3],8'h0d);
        t[4*c+2] = gmul(a[4*c],8'h0d)^gmul(a[4*c+1],8'h09)^gmul(a[4*c+2],8'h0e)^gmul(a[4*c+3],8'h0b);
        t[4*c+3] = gmul(a[4*c],8'h0b)^gmul(a[4*c+1],8'h0d)^gmul(a[4*c+2],8'h09)^gmul(a[4*c+3],8'h0e);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= NR) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk[r] = '0;
    end
  endtask

  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[NR];
    for (int r = NR - 1; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
    return s;
  endfunction

  // External key store and datapath
  assign round_key = rk[key_idx];
  assign dp_result = inv_round(dp_state, dp_key, dp_last);

  // ---------------- reference model ----------------
  bit           m_busy = 1'b0;
  int           m_done = 0;
  logic [127:0] m_state = '0, m_pt = '0;
  int           m_acc_n = 0, m_last_acc = 0, m_prev_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_busy  <= 1'b0;
      m_done  <= 0;
      m_state <= '0;
    end else if (!m_busy) begin
      if (in_valid && key_valid) begin
        m_busy     <= 1'b1;
        m_done     <= 0;
        m_state    <= in_data ^ rk[NR];
        m_pt       <= ref_dec(in_data);
        m_acc_n    <= m_acc_n + 1;
        m_prev_acc <= m_last_acc;
        m_last_acc <= cyc;
      end
    end else if (m_done < NR) begin
      if (key_valid) begin
        m_state <= inv_round(m_state, rk[NR-1-m_done], m_done == NR - 1);
        m_done  <= m_done + 1;
      end
    end else if (out_ready) begin
      m_busy <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, !m_busy && key_valid);
      chk("busy", busy, m_busy);
      chk("out_valid", out_valid, m_busy && m_done == NR);
      chk("dp_last", dp_last, m_busy && m_done == NR - 1);
      if (!m_busy) begin
        chk("key_idx_idle", key_idx, NR);
      end else if (m_done < NR) begin
        chk("key_idx", key_idx, NR - 1 - m_done);
        chk("dp_state", dp_state, m_state);
        chk("dp_key", dp_key, rk[NR-1-m_done]);
      end else begin
        chk("out_data", out_data, m_pt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt,
                           input int stall_at, input int stall_len);
    int n;
    in_data = ct; in_valid = 1'b1; key_valid = 1'b1;
    chk("accept_key_idx", key_idx, NR);
    chk("accept_in_ready", in_ready, 1);
    do_cycle();
    in_valid = 1'b0;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (!out_valid && n < 60) begin
      if (stall_len == 0 && n < NR) begin
        chk("trace_key_idx", key_idx, NR - 1 - n);
        chk("trace_dp_last", dp_last, n == NR - 1);
      end
      key_valid = !(n >= stall_at && n < stall_at + stall_len);
      do_cycle();
      n++;
    end
    key_valid = 1'b1;
    chk("latency", n + 1, NR + 1 + stall_len);
    chk("plaintext", out_data, pt);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0; out_ready = 1'b1; key_valid = 1'b1;
    while (m_busy && n < 40) begin
      do_cycle();
      n++;
    end
    chk("drain_idle", m_busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int base, n;
    build_tables();
    set_key(FKEY);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key_idx", key_idx, NR);
    chk("rst_dp_last", dp_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("pin_isbox00", isbox[0], 8'h52);
    chk("pin_rk10", rk[NR], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("pin_ref_dec", ref_dec(CT), PT);
    n_rst = 1'b1;
    chk_en = 1'b1;
    do_cycle();

    // FIPS vector with key-index trace, then backpressure in DONE
    run_block(CT, PT, 0, 0);
    in_valid = 1'b1; in_data = CT;
    for (int i = 0; i < 5; i++) begin
      do_cycle();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, PT);
      chk("bp_in_ready", in_ready, 0);
    end

    // Back-to-back: two further blocks with out_ready held high
    base = m_acc_n;
    out_ready = 1'b1;
    n = 0;
    while (m_acc_n < base + 2 && n < 60) begin
      do_cycle();
      n++;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", m_acc_n, base + 2);
    chk("b2b_spacing", m_last_acc - m_prev_acc, NR + 2);
    drain();

    // Async reset in the middle of round 5
    in_data = CT; in_valid = 1'b1;
    do_cycle();
    in_valid = 1'b0;
    repeat (5) do_cycle();
    n_rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_key_idx", key_idx, NR);
    chk("arst_dp_last", dp_last, 0);
    chk("arst_out_data", out_data, 0);
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    repeat (3) do_cycle();
    run_block(CT, PT, 0, 0);
    drain();

`ifdef AES_DEC_KEY_STALL_EN
    run_block(CT, PT, 4, 3);
    drain();
`endif

    // Random traffic under several random keys
    for (int k = 0; k < 4; k++) begin
      drain();
      set_key({$urandom, $urandom, $urandom, $urandom});
      for (int c = 0; c < 300; c++) begin
        in_valid  = ($urandom % 2) == 0;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        out_ready = ($urandom % 10) < 6;
`ifdef AES_DEC_KEY_STALL_EN
        key_valid = ($urandom % 5) != 0;
`endif
        do_cycle();
      end
    end
    drain();
    repeat (2) do_cycle();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
